// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, runtime CPOL/CPHA/bit order/divider and one-hot slave selects.
// Mode, bit order and divider are latched when a word is popped, so bus writes only affect later words.
//
// state | meaning
// IDLE  | no word in flight; SCLK parked at CONTROL.CPOL
// LEAD  | SS asserted for one half-period before the first SCLK edge
// SHIFT | remaining SCLK edges, one per half-period
// TRAIL | half-period with SCLK idle; received word pushed to RX FIFO

module spi_master_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_SLAVES = 1,
   parameter int DIV_RESET  = 9
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            addr,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [15:0]           wdata,
   output logic [15:0]           rdata,
   output logic                  irq,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic [NUM_SLAVES-1:0] SS_n
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = $clog2(2*DATA_WIDTH + 1);
   localparam logic [AW:0]           PTR_ONE    = 1;
   localparam logic [EW-1:0]         EDGE_ONE   = 1;
   localparam logic [EW-1:0]         EDGES      = EW'(2*DATA_WIDTH);
   localparam logic [NUM_SLAVES-1:0] SSEL_RESET = 1;

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;
   state_t state, state_nxt;

   logic [6:0]            ctrl;
   logic [7:0]            div;
   logic [NUM_SLAVES-1:0] ssel;
   logic                  ruf, roe, toe;

   logic                  cpha_l, lsb_l;
   logic [7:0]            div_l, cnt;
   logic [EW-1:0]         edges_left;
   logic [DATA_WIDTH-1:0] tx_sr, rx_sr;

   logic                  load, sclk_edge, rx_push;
   logic                  busy, tc, leading, last_edge;

   logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0]           tx_wp, tx_rp, rx_wp, rx_rp;
   logic                  tx_empty, tx_full, rx_empty, rx_full;
   logic                  tx_wr, tx_push, tx_pop, rx_pop, rx_accept;
   logic [DATA_WIDTH-1:0] tx_head, rx_head;
   logic [6:0]            status;
   logic [15:0]           rd_mux;
   logic                  unused_bits;

   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic lsb,
                                                      input logic b);
      return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   assign unused_bits = ^wdata;

   assign tx_empty  = (tx_wp == tx_rp);
   assign tx_full   = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty  = (rx_wp == rx_rp);
   assign rx_full   = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign tx_head   = tx_mem[tx_rp[AW-1:0]];
   assign rx_head   = rx_mem[rx_rp[AW-1:0]];

   // A full FIFO still accepts a push when it is popped in the same cycle.
   assign tx_wr     = wr && (addr == 3'd1);
   assign tx_pop    = load;
   assign tx_push   = tx_wr && (!tx_full || tx_pop);
   assign rx_pop    = rd && (addr == 3'd0) && !rx_empty;
   assign rx_accept = rx_push && (!rx_full || rx_pop);

   assign busy      = (state != S_IDLE);
   assign tc        = (cnt == 8'd0);
   assign leading   = ~edges_left[0];
   assign last_edge = (edges_left == EDGE_ONE);
   assign status    = {ruf, roe, toe, busy, !rx_empty, !tx_full, tx_empty && !busy};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!tx_empty) state_nxt = S_LEAD;
         S_LEAD:  if (tc) state_nxt = S_SHIFT;
         S_SHIFT: if (tc && last_edge) state_nxt = S_TRAIL;
         S_TRAIL: if (tc) state_nxt = tx_empty ? S_IDLE : S_LEAD;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      sclk_edge = 1'b0;
      rx_push   = 1'b0;
      case (state)
         S_IDLE:  load = !tx_empty;
         S_LEAD:  sclk_edge = tc;
         S_SHIFT: sclk_edge = tc;
         S_TRAIL: begin
            rx_push = tc;
            load    = tc && !tx_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push)   tx_wp <= tx_wp + PTR_ONE;
         if (tx_pop)    tx_rp <= tx_rp + PTR_ONE;
         if (rx_accept) rx_wp <= rx_wp + PTR_ONE;
         if (rx_pop)    rx_rp <= rx_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push)   tx_mem[tx_wp[AW-1:0]] <= wdata[DATA_WIDTH-1:0];
      if (rx_accept) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
   end

   // With CPHA=0 the first bit goes out at load; otherwise each bit leaves on a leading edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpha_l     <= 1'b0;
         lsb_l      <= 1'b0;
         div_l      <= '0;
         cnt        <= '0;
         edges_left <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         SCLK       <= 1'b0;
         MOSI       <= 1'b0;
      end else if (load) begin
         cpha_l     <= ctrl[1];
         lsb_l      <= ctrl[2];
         div_l      <= div;
         cnt        <= div;
         edges_left <= EDGES;
         SCLK       <= ctrl[0];
         if (ctrl[1]) begin
            tx_sr <= tx_head;
         end else begin
            tx_sr <= shift_out(tx_head, ctrl[2]);
            MOSI  <= out_bit(tx_head, ctrl[2]);
         end
      end else if (state == S_IDLE) begin
         SCLK <= ctrl[0];
      end else begin
         cnt <= tc ? div_l : cnt - 8'd1;
         if (sclk_edge) begin
            SCLK       <= ~SCLK;
            edges_left <= edges_left - EDGE_ONE;
            if (leading != cpha_l) rx_sr <= shift_in(rx_sr, lsb_l, MISO);
            if (cpha_l ? leading : (!leading && !last_edge)) begin
               MOSI  <= out_bit(tx_sr, lsb_l);
               tx_sr <= shift_out(tx_sr, lsb_l);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) SS_n <= '1;
      else          SS_n <= (ctrl[3] || state_nxt != S_IDLE) ? ~ssel : '1;
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         3'd0: if (!rx_empty) rd_mux[DATA_WIDTH-1:0] = rx_head;
         3'd2: rd_mux[6:0] = status;
         3'd3: rd_mux[6:0] = ctrl;
         3'd4: rd_mux[7:0] = div;
         3'd5: rd_mux[NUM_SLAVES-1:0] = ssel;
         default: ;
      endcase
   end

   // Flag sets are placed after the STATUS-write clear so a same-cycle event is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl  <= '0;
         div   <= 8'(DIV_RESET);
         ssel  <= SSEL_RESET;
         ruf   <= 1'b0;
         roe   <= 1'b0;
         toe   <= 1'b0;
         rdata <= '0;
         irq   <= 1'b0;
      end else begin
         if (wr) begin
            case (addr)
               3'd2: begin
                  ruf <= 1'b0;
                  roe <= 1'b0;
                  toe <= 1'b0;
               end
               3'd3: ctrl <= wdata[6:0];
               3'd4: div  <= wdata[7:0];
               3'd5: ssel <= wdata[NUM_SLAVES-1:0];
               default: ;
            endcase
         end
         if (tx_wr && !tx_push)                   toe <= 1'b1;
         if (rx_push && !rx_accept)               roe <= 1'b1;
         if (rd && (addr == 3'd0) && rx_empty)    ruf <= 1'b1;
         if (rd) rdata <= rd_mux;
         irq <= (status[0] & ctrl[4]) | (status[2] & ctrl[5]) | ((toe | roe | ruf) & ctrl[6]);
      end
   end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: MISO looped to MOSI, a passive slave model, bus-level checks.
module tb_spi_master_fifo;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [15:0] wdata = 16'd0;
   logic [15:0] rdata;
   logic        irq, SCLK, MOSI, MISO;
   logic [3:0]  SS_n;

   assign MISO = MOSI;

   spi_master_fifo #(
      .DATA_WIDTH(8), .FIFO_DEPTH(8), .NUM_SLAVES(4), .DIV_RESET(9)
   ) dut (
      .clk(clk), .reset_n(reset_n), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
      .rdata(rdata), .irq(irq), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_rise = 0;
   int n_ss_rise = 0;
   int slv_n = 0;
   time t0 = 0, t1 = 0;
   logic [7:0] slv_sr = 8'd0;
   logic t_cpol = 1'b0, t_cpha = 1'b0, t_lsb = 1'b0;

   always @(posedge SCLK) begin
      if (n_rise == 0) t0 = $time;
      else if (n_rise == 1) t1 = $time;
      n_rise++;
   end

   always @(posedge SS_n[0]) n_ss_rise++;

   // Slave samples on the leading edge for CPHA=0, trailing edge for CPHA=1.
   always @(SCLK) begin
      if (SCLK !== 1'bx && ((SCLK != t_cpol) != t_cpha)) begin
         slv_sr = t_lsb ? {MOSI, slv_sr[7:1]} : {slv_sr[6:0], MOSI};
         slv_n++;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic wait_idle(input int budget);
      logic [15:0] s;
      int n;
      s = 16'd0;
      n = 0;
      while (s[0] !== 1'b1 && n < budget) begin
         rd_reg(3'd2, s);
         n++;
      end
      check("idle_reached", {15'd0, s[0]}, 16'd1);
   endtask

   task automatic wait_sclk(input logic v);
      int n;
      n = 0;
      while (SCLK !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("sclk_level", {15'd0, SCLK}, {15'd0, v});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      logic [7:0]  dat [10];
      int          n;
      for (int i = 0; i < 10; i++) dat[i] = 8'(16 + 17*i);

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'd0);
      check("rst_mosi", {15'd0, MOSI}, 16'd0);
      check("rst_ss_n", 16'(SS_n), 16'h000F);
      check("rst_sclk", {15'd0, SCLK}, 16'd0);
      reset_n = 1'b1;
      rd_reg(3'd2, r); check("rst_status", r, 16'h0003);
      rd_reg(3'd4, r); check("rst_div", r, 16'd9);
      rd_reg(3'd5, r); check("rst_ssel", r, 16'h0001);
      rd_reg(3'd3, r); check("rst_ctrl", r, 16'h0000);
      rd_reg(3'd7, r); check("unmapped", r, 16'h0000);

      // Mode 0, DIV=1, MSB first, IE_RXNE
      wr_reg(3'd4, 16'd1);
      wr_reg(3'd3, 16'h0020);
      n_rise = 0; slv_n = 0; slv_sr = 8'd0;
      wr_reg(3'd1, 16'h00A5);
      repeat (2) @(negedge clk);
      check("m0_ss_active", 16'(SS_n), 16'h000E);
      wait_idle(200);
      check("m0_pulses", 16'(n_rise), 16'd8);
      check("m0_sclk_period", 16'(t1 - t0), 16'd40);
      check("m0_slave_rx", {8'd0, slv_sr}, 16'h00A5);
      check("m0_slave_bits", 16'(slv_n), 16'd8);
      check("m0_ss_release", 16'(SS_n), 16'h000F);
      check("m0_irq_rxne", {15'd0, irq}, 16'd1);
      rd_reg(3'd0, r); check("m0_rxdata", r, 16'h00A5);
      @(negedge clk);
      check("m0_irq_clear", {15'd0, irq}, 16'd0);

      // CPOL=1, CPHA=1, LSB first
      wr_reg(3'd3, 16'h0007);
      repeat (2) @(negedge clk);
      check("m3_sclk_idle", {15'd0, SCLK}, 16'd1);
      t_cpol = 1'b1; t_cpha = 1'b1; t_lsb = 1'b1;
      slv_n = 0; slv_sr = 8'd0;
      wr_reg(3'd1, 16'h0001);
      wait_sclk(1'b0);
      check("m3_first_bit", {15'd0, MOSI}, 16'd1);
      wait_sclk(1'b1);
      wait_sclk(1'b0);
      check("m3_second_bit", {15'd0, MOSI}, 16'd0);
      wait_idle(200);
      check("m3_slave_rx", {8'd0, slv_sr}, 16'h0001);
      check("m3_slave_bits", 16'(slv_n), 16'd8);
      rd_reg(3'd0, r); check("m3_rxdata", r, 16'h0001);
      check("m3_sclk_park", {15'd0, SCLK}, 16'd1);

      // TX overflow with a stalled first word, then RX overflow/underflow
      wr_reg(3'd3, 16'h0000);
      t_cpol = 1'b0; t_cpha = 1'b0; t_lsb = 1'b0;
      wr_reg(3'd4, 16'd255);
      n_rise = 0; n_ss_rise = 0;
      for (int i = 0; i < 10; i++) wr_reg(3'd1, {8'd0, dat[i]});
      rd_reg(3'd2, r); check("ovf_status_busy", r, 16'h0018);
      wr_reg(3'd4, 16'd0);
      wait_idle(3000);
      check("ovf_pulses", 16'(n_rise), 16'd72);
      check("ovf_ss_rises", 16'(n_ss_rise), 16'd1);
      rd_reg(3'd2, r); check("ovf_status_done", r, 16'h0037);
      for (int i = 0; i < 8; i++) begin
         rd_reg(3'd0, r); check("ovf_rx_order", r, {8'd0, dat[i]});
      end
      rd_reg(3'd0, r); check("ruf_rdata", r, 16'h0000);
      rd_reg(3'd2, r); check("ruf_status", r, 16'h0073);
      wr_reg(3'd2, 16'h0000);
      rd_reg(3'd2, r); check("flags_cleared", r, 16'h0003);

      // Slave select mask and forced select
      wr_reg(3'd4, 16'd1);
      wr_reg(3'd5, 16'h0004);
      rd_reg(3'd5, r); check("ssel_read", r, 16'h0004);
      check("ssel_idle", 16'(SS_n), 16'h000F);
      wr_reg(3'd1, 16'h005A);
      repeat (2) @(negedge clk);
      check("ssel_word", 16'(SS_n), 16'h000B);
      wait_idle(200);
      check("ssel_after", 16'(SS_n), 16'h000F);
      rd_reg(3'd0, r); check("ssel_rxdata", r, 16'h005A);
      wr_reg(3'd3, 16'h0008);
      @(negedge clk);
      check("sso_idle", 16'(SS_n), 16'h000B);
      wr_reg(3'd3, 16'h0000);
      @(negedge clk);
      check("sso_off", 16'(SS_n), 16'h000F);

      // Reset in the middle of a word
      wr_reg(3'd5, 16'h0001);
      wr_reg(3'd4, 16'd3);
      n_rise = 0;
      wr_reg(3'd1, 16'h003C);
      wr_reg(3'd1, 16'h00C3);
      n = 0;
      while (!(n_rise >= 4 && SCLK === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("mid_bit4", {15'd0, SCLK}, 16'd1);
      check("mid_ss_active", 16'(SS_n), 16'h000E);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ss_n", 16'(SS_n), 16'h000F);
      check("mid_rst_sclk", {15'd0, SCLK}, 16'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rd_reg(3'd2, r); check("post_rst_status", r, 16'h0003);
      rd_reg(3'd4, r); check("post_rst_div", r, 16'd9);
      rd_reg(3'd5, r); check("post_rst_ssel", r, 16'h0001);
      rd_reg(3'd0, r); check("post_rst_rx_empty", r, 16'h0000);
      n = n_rise;
      repeat (30) @(negedge clk);
      check("post_rst_no_sclk", 16'(n_rise - n), 16'd0);
      check("post_rst_ss_idle", 16'(SS_n), 16'h000F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
